// File: rtl/fp_accum_seq_if.sv
// Handshake bundle for fp_accum_seq: operand stream, adder start/done, result stream, status.
// master = environment side, slave = sequencer side.
interface fp_accum_seq_if #(
  parameter int LEN_W = 8
);
  logic             acc_start;
  logic [LEN_W-1:0] cfg_len;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_start;
  logic [31:0]      add_sum;
  logic             add_done;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             err;

  modport master (
    output acc_start, cfg_len, in_data, in_valid, add_sum, add_done, out_ready,
    input  in_ready, add_a, add_b, add_start, out_data, out_valid, busy, err
  );

  modport slave (
    input  acc_start, cfg_len, in_data, in_valid, add_sum, add_done, out_ready,
    output in_ready, add_a, add_b, add_start, out_data, out_valid, busy, err
  );
endinterface

// File: rtl/fp_accum_seq.sv
// Floating-point accumulation sequencer: streams operands through an external adder and returns the sum.
// Optional add_done watchdog enabled by defining FPACC_TIMEOUT_EN.
module fp_accum_seq #(
  parameter int LEN_W   = 8,
  parameter int TMO_CYC = 16
) (
  input logic          clk,
  input logic          reset_n,
  fp_accum_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    ISSUE,
    RELEASE,
    OUT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      op_q, op_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             add_start_q, in_ready_q, out_valid_q, busy_q;

`ifdef FPACC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    count_d = count_q;
    len_d   = len_q;
`ifdef FPACC_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.acc_start) begin
          acc_d = 32'h0000_0000;
          if (bus.cfg_len != '0) begin
            len_d   = bus.cfg_len;
            count_d = '0;
            state_d = FETCH;
          end else begin
            state_d = OUT;
          end
        end
      end
      FETCH: begin
        if (bus.in_valid) begin
          op_d    = bus.in_data;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // The adder samples add_a/add_b the cycle before start, so hold start low once.
        state_d = ISSUE;
`ifdef FPACC_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ISSUE: begin
        if (bus.add_done) begin
          acc_d   = bus.add_sum;
          state_d = RELEASE;
`ifdef FPACC_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
`ifdef FPACC_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = OUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      RELEASE: begin
        if (!bus.add_done) begin
          count_d = count_q + LEN_W'(1);
          state_d = (count_d == len_q) ? OUT : FETCH;
        end
`ifdef FPACC_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = OUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
`ifdef FPACC_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= 32'h0000_0000;
      op_q        <= 32'h0000_0000;
      count_q     <= '0;
      len_q       <= '0;
      add_start_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      count_q     <= count_d;
      len_q       <= len_d;
      // Handshake outputs are registered from the next state so they are glitch-free flops.
      add_start_q <= (state_d == ISSUE);
      in_ready_q  <= (state_d == FETCH);
      out_valid_q <= (state_d == OUT);
      busy_q      <= (state_d != IDLE);
    end
  end

`ifdef FPACC_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.add_a     = acc_q;
  assign bus.add_b     = op_q;
  assign bus.add_start = add_start_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.busy      = busy_q;

endmodule
